// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: queues bottle and change requests and drives
// the bottle motor and coin hopper one item at a time with stuck-actuator fault.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   i_bottle_req        one bottle request per cycle held high
//   i_change_req        one change-coin request per cycle held high
//   i_motor_done        bottle motor finished (looked at only while vending)
//   i_hopper_done       hopper ejected a coin (looked at only while paying out)
//   i_fault_clr         service clear (looked at only while faulted)
//   o_motor_on          bottle motor drive
//   o_hopper_on         coin hopper drive
//   o_busy              serving an item or in the post-item gap
//   o_fault             stuck actuator latched
//   o_overflow          a request was dropped because its counter was full
//   o_pend_bottles      bottles still owed
//   o_pend_change       change coins still owed

module vend_dispense_ctrl #(
    parameter int CNT_W       = 3,
    parameter int MAX_PENDING = 7,
    parameter int ACT_TIMEOUT = 255,
    parameter int TMR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_bottle_req,
    input  logic             i_change_req,
    input  logic             i_motor_done,
    input  logic             i_hopper_done,
    input  logic             i_fault_clr,
    output logic             o_motor_on,
    output logic             o_hopper_on,
    output logic             o_busy,
    output logic             o_fault,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_pend_bottles,
    output logic [CNT_W-1:0] o_pend_change
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_PAYOUT,
        S_GAP,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
    localparam logic [TMR_W-1:0] TMO     = TMR_W'(ACT_TIMEOUT);

    state_t             r_state;
    logic [TMR_W-1:0]   r_tmr;
    logic [CNT_W-1:0]   r_pend_b;
    logic [CNT_W-1:0]   r_pend_c;
    logic               r_motor_on;
    logic               r_hopper_on;
    logic               r_busy;
    logic               r_fault;
    logic               r_ovf;

    state_t             w_nxt;
    logic [TMR_W-1:0]   w_tmr_inc;
    logic               w_dec_b;
    logic               w_dec_c;
    logic               w_drop_b;
    logic               w_drop_c;
    logic               w_tmr_run;

    // w_tmr_inc is the number of cycles the drive will have been on once
    // this cycle completes; reaching the limit without a done means stuck.
    always_comb begin
        w_nxt     = r_state;
        w_dec_b   = 1'b0;
        w_dec_c   = 1'b0;
        w_tmr_inc = r_tmr + 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (r_pend_b != '0) begin
                    w_nxt = S_VEND;
                end else if (r_pend_c != '0) begin
                    w_nxt = S_PAYOUT;
                end
            end
            S_VEND: begin
                if (i_motor_done) begin
                    w_nxt   = S_GAP;
                    w_dec_b = (r_pend_b != '0);
                end else if (w_tmr_inc == TMO) begin
                    w_nxt = S_FAULT;
                end
            end
            S_PAYOUT: begin
                if (i_hopper_done) begin
                    w_nxt   = S_GAP;
                    w_dec_c = (r_pend_c != '0);
                end else if (w_tmr_inc == TMO) begin
                    w_nxt = S_FAULT;
                end
            end
            S_GAP: begin
                w_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (i_fault_clr) begin
                    w_nxt = S_IDLE;
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    // A request coinciding with a decrement nets to zero, so it is never
    // dropped even when the counter is full.
    assign w_drop_b = i_bottle_req && !w_dec_b && (r_pend_b == MAX_CNT);
    assign w_drop_c = i_change_req && !w_dec_c && (r_pend_c == MAX_CNT);

    // Timer only runs while staying in an actuator state; any entry
    // into VEND/PAYOUT therefore starts from zero.
    assign w_tmr_run = (w_nxt == r_state) &&
                       ((r_state == S_VEND) || (r_state == S_PAYOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_pend_b    <= '0;
            r_pend_c    <= '0;
            r_motor_on  <= 1'b0;
            r_hopper_on <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_tmr   <= w_tmr_run ? w_tmr_inc : '0;

            if (i_bottle_req && !w_dec_b && !w_drop_b) begin
                r_pend_b <= r_pend_b + 1'b1;
            end else if (!i_bottle_req && w_dec_b) begin
                r_pend_b <= r_pend_b - 1'b1;
            end

            if (i_change_req && !w_dec_c && !w_drop_c) begin
                r_pend_c <= r_pend_c + 1'b1;
            end else if (!i_change_req && w_dec_c) begin
                r_pend_c <= r_pend_c - 1'b1;
            end

            r_ovf       <= w_drop_b | w_drop_c;
            r_motor_on  <= (w_nxt == S_VEND);
            r_hopper_on <= (w_nxt == S_PAYOUT);
            r_busy      <= (w_nxt == S_VEND) || (w_nxt == S_PAYOUT) ||
                           (w_nxt == S_GAP);
            r_fault     <= (w_nxt == S_FAULT);
        end
    end

    assign o_motor_on     = r_motor_on;
    assign o_hopper_on    = r_hopper_on;
    assign o_busy         = r_busy;
    assign o_fault        = r_fault;
    assign o_overflow     = r_ovf;
    assign o_pend_bottles = r_pend_b;
    assign o_pend_change  = r_pend_c;

endmodule
